ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 176 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch front end. It issues one instruction-memory request at a
// time, collects the returned words into a small circular fetch queue and
// presents the queue head to the decode stage. A flush (taken branch/jump)
// empties the queue and turns any in-flight request into a drained, discarded
// response.
//
// Ports
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   asynchronous reset, active-low
//   start_i      in   1   fetch enable (0 = no new request issued)
//   pc_i         in  32   current PC from the PC register
//   pc_stall_o   out  1   1 = PC register holds, 0 = PC loads next PC
//   flush_i      in   1   taken branch/jump, discard fetched/in-flight work
//   imem_req_o   out  1   instruction-memory request
//   imem_addr_o  out 32   request address, stable while imem_req_o = 1
//   imem_ack_i   in   1   memory returns data this cycle
//   imem_data_i  in  32   returned instruction word
//   dec_valid_o  out  1   queue head valid
//   dec_ready_i  in   1   decode accepts the head this cycle
//   dec_instr_o  out 32   head instruction
//   dec_pc_o     out 32   head instruction address
//   dec_pc4_o    out 32   head instruction address + 4
//
// DEPTH must be a power of two in 2..8 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    output logic        pc_stall_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] dec_instr_o,
    output logic [31:0] dec_pc_o,
    output logic [31:0] dec_pc4_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_req;
    logic [31:0]     r_addr;

    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_q_instr [DEPTH];
    logic [31:0]     r_q_pc    [DEPTH];

    logic            w_push;
    logic            w_pop;
    logic            w_room;
    logic            w_issue;
    logic [31:0]     w_head_pc;

    // A response only becomes a queue entry if it answers a live request and
    // no branch redirect arrives in the same cycle.
    assign w_push  = (r_state == S_REQ) && imem_ack_i && !flush_i;
    assign w_pop   = dec_valid_o && dec_ready_i;
    // Issue is gated on the current count only; with a single outstanding
    // request this guarantees the eventual push always finds a free slot.
    assign w_room  = (r_count < CW'(DEPTH));
    assign w_issue = (r_state == S_IDLE) && start_i && !flush_i && w_room;

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_addr  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= pc_i;
                    end
                end
                S_REQ: begin
                    if (imem_ack_i) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end else if (flush_i) begin
                        // The memory still owes us a response; wait for it
                        // and throw it away rather than issuing on top of it.
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack_i) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Queue pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            // A same-cycle pop has already been seen by decode; clearing
            // wins regardless.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage carries no reset; only the occupancy decides validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_data_i;
            r_q_pc[r_wr_ptr]    <= r_addr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req_o  = r_req;
    assign imem_addr_o = r_addr;

    // The PC advances once per accepted instruction and loads the branch
    // target on a flush. Reset holds it.
    assign pc_stall_o  = !(rst_i && (w_push || flush_i));

    assign w_head_pc   = r_q_pc[r_rd_ptr];
    assign dec_valid_o = (r_count != '0);
    assign dec_instr_o = r_q_instr[r_rd_ptr];
    assign dec_pc_o    = w_head_pc;
    assign dec_pc4_o   = w_head_pc + 32'd4;

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
// Directed bench for ifetch_unit. Expected queue entries are pushed to a
// scoreboard when the bench returns a response that should be accepted, and
// popped/compared when decode takes the head.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam int DEPTH = 2;
    localparam int M_IDLE  = 0;
    localparam int M_REQ   = 1;
    localparam int M_DRAIN = 2;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        pc_stall_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_pc4_o;

    ifetch_unit #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .pc_i        (pc_i),
        .pc_stall_o  (pc_stall_o),
        .flush_i     (flush_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .dec_valid_o (dec_valid_o),
        .dec_ready_i (dec_ready_i),
        .dec_instr_o (dec_instr_o),
        .dec_pc_o    (dec_pc_o),
        .dec_pc4_o   (dec_pc4_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int          m_state = M_IDLE;
    logic [31:0] m_addr  = 32'd0;
    logic [31:0] m_pc    = 32'd0;
    logic [31:0] flush_tgt = 32'd0;
    logic [63:0] sb[$];
    logic [31:0] pop_log[$];
    int          n_issue = 0;
    bit          auto_ack = 1'b0;
    int          lat_mod  = 0;

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // One clock cycle: entered at posedge+1, left at the next posedge+1.
    task automatic cycle();
        logic        e_push;
        logic        e_pop;
        logic        e_issue;
        logic        e_valid;
        pc_i = m_pc;
        if (auto_ack) begin
            imem_ack_i  = imem_req_o && ($urandom_range(0, lat_mod) == 0);
            imem_data_i = dfun(imem_addr_o);
        end
        #1;
        e_valid = (sb.size() != 0);
        e_push  = (m_state == M_REQ) && imem_ack_i && !flush_i;
        e_pop   = e_valid && dec_ready_i;
        e_issue = (m_state == M_IDLE) && start_i && !flush_i && (sb.size() < DEPTH);
        chk("req", 32'(imem_req_o), 32'(m_state != M_IDLE));
        if (m_state != M_IDLE) chk("addr", imem_addr_o, m_addr);
        chk("stall", 32'(pc_stall_o), 32'(!(e_push || flush_i)));
        chk("valid", 32'(dec_valid_o), 32'(e_valid));
        if (e_valid) begin
            chk("instr", dec_instr_o, sb[0][31:0]);
            chk("pc",    dec_pc_o,    sb[0][63:32]);
            chk("pc4",   dec_pc4_o,   sb[0][63:32] + 32'd4);
        end
        @(posedge clk_i);
        #1;
        if (e_pop) begin
            pop_log.push_back(sb[0][63:32]);
            void'(sb.pop_front());
        end
        if (flush_i) sb.delete();
        else if (e_push) sb.push_back({m_addr, imem_data_i});
        if (flush_i) m_pc = flush_tgt;
        else if (e_push) m_pc = m_pc + 32'd4;
        case (m_state)
            M_IDLE:  if (e_issue) begin m_state = M_REQ; m_addr = pc_i; n_issue++; end
            M_REQ:   if (imem_ack_i) m_state = M_IDLE; else if (flush_i) m_state = M_DRAIN;
            M_DRAIN: if (imem_ack_i) m_state = M_IDLE;
            default: m_state = M_IDLE;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_i = 1'b0; start_i = 1'b0; pc_i = 32'd0; flush_i = 1'b0;
        imem_ack_i = 1'b0; imem_data_i = 32'd0; dec_ready_i = 1'b0;

        // Reset state
        #2;
        chk("rst_req",   32'(imem_req_o),  32'd0);
        chk("rst_valid", 32'(dec_valid_o), 32'd0);
        chk("rst_stall", 32'(pc_stall_o),  32'd1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Basic fetch
        m_pc = 32'h100; start_i = 1'b1; dec_ready_i = 1'b0;
        cycle();
        chk("b_req",  32'(imem_req_o), 32'd1);
        chk("b_addr", imem_addr_o, 32'h100);
        imem_ack_i = 1'b1; imem_data_i = 32'h8C220004; start_i = 1'b0;
        #1;
        chk("b_stall0", 32'(pc_stall_o), 32'd0);
        cycle();
        imem_ack_i = 1'b0;
        #1;
        chk("b_stall1", 32'(pc_stall_o),  32'd1);
        chk("b_valid",  32'(dec_valid_o), 32'd1);
        chk("b_instr",  dec_instr_o, 32'h8C220004);
        chk("b_pc",     dec_pc_o,    32'h100);
        chk("b_pc4",    dec_pc4_o,   32'h104);
        dec_ready_i = 1'b1;
        cycle();
        dec_ready_i = 1'b0;
        cycle();
        chk("b_empty", 32'(dec_valid_o), 32'd0);

        // Full queue
        m_pc = 32'h300; start_i = 1'b1; auto_ack = 1'b1; lat_mod = 0;
        repeat (6) cycle();
        chk("f_req",   32'(imem_req_o),  32'd0);
        chk("f_valid", 32'(dec_valid_o), 32'd1);
        chk("f_head",  dec_pc_o, 32'h300);
        dec_ready_i = 1'b1;
        cycle();
        dec_ready_i = 1'b0;
        cycle();
        chk("f_reissue", 32'(imem_req_o), 32'd1);
        chk("f_addr",    imem_addr_o, 32'h308);
        cycle();
        repeat (2) cycle();
        chk("f_req2", 32'(imem_req_o), 32'd0);
        start_i = 1'b0; dec_ready_i = 1'b1;
        repeat (3) cycle();
        dec_ready_i = 1'b0;
        chk("f_drained", 32'(dec_valid_o), 32'd0);

        // Flush with a request in flight
        auto_ack = 1'b0; imem_ack_i = 1'b0;
        m_pc = 32'h200; start_i = 1'b1; dec_ready_i = 1'b1;
        cycle();
        chk("fl_addr", imem_addr_o, 32'h200);
        flush_i = 1'b1; flush_tgt = 32'h400;
        #1;
        chk("fl_stall", 32'(pc_stall_o), 32'd0);
        cycle();
        flush_i = 1'b0;
        cycle();
        cycle();
        chk("fl_drain_req",  32'(imem_req_o), 32'd1);
        chk("fl_drain_addr", imem_addr_o, 32'h200);
        imem_ack_i = 1'b1; imem_data_i = 32'hDEADBEEF;
        cycle();
        imem_ack_i = 1'b0;
        chk("fl_novalid", 32'(dec_valid_o), 32'd0);
        cycle();
        chk("fl_newaddr", imem_addr_o, 32'h400);
        imem_ack_i = 1'b1; imem_data_i = 32'h11111111;
        cycle();
        imem_ack_i = 1'b0; start_i = 1'b0;
        chk("fl_instr", dec_instr_o, 32'h11111111);
        cycle();
        dec_ready_i = 1'b0;

        // Flush with ack in the same cycle, one entry queued
        m_pc = 32'h500; start_i = 1'b1; auto_ack = 1'b1;
        cycle();
        cycle();
        cycle();
        auto_ack = 1'b0;
        imem_ack_i = 1'b1; imem_data_i = 32'h22222222;
        flush_i = 1'b1; flush_tgt = 32'h800; start_i = 1'b0;
        cycle();
        flush_i = 1'b0; imem_ack_i = 1'b0;
        chk("ff_valid", 32'(dec_valid_o), 32'd0);
        chk("ff_req",   32'(imem_req_o),  32'd0);
        cycle();

        // Wrap-around with random decode back-pressure
        m_pc = 32'h0; n_issue = 0; pop_log.delete();
        auto_ack = 1'b1; lat_mod = 1;
        for (int i = 0; i < 400 && pop_log.size() < 10; i++) begin
            start_i     = (n_issue < 10);
            dec_ready_i = 1'($urandom_range(0, 1));
            cycle();
        end
        start_i = 1'b0; dec_ready_i = 1'b0; auto_ack = 1'b0; imem_ack_i = 1'b0;
        chk("wrap_count", 32'(pop_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < pop_log.size(); i++)
            chk($sformatf("wrap_pc%0d", i), pop_log[i], 32'(i * 4));
        repeat (2) cycle();

        // Reset mid-request with one entry queued
        m_pc = 32'h600; start_i = 1'b1; auto_ack = 1'b1; lat_mod = 0;
        cycle();
        cycle();
        cycle();
        auto_ack = 1'b0; imem_ack_i = 1'b0; start_i = 1'b0;
        chk("r_pre_req",   32'(imem_req_o),  32'd1);
        chk("r_pre_valid", 32'(dec_valid_o), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("r_req",   32'(imem_req_o),  32'd0);
        chk("r_valid", 32'(dec_valid_o), 32'd0);
        chk("r_stall", 32'(pc_stall_o),  32'd1);
        m_state = M_IDLE; sb.delete();
        imem_ack_i = 1'b1; imem_data_i = 32'h33333333;
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("r_stray", 32'(dec_valid_o), 32'd0);
        m_pc = 32'h700; start_i = 1'b1;
        cycle();
        chk("r_addr", imem_addr_o, 32'h700);
        imem_ack_i = 1'b1; imem_data_i = 32'h44444444; start_i = 1'b0;
        cycle();
        imem_ack_i = 1'b0;
        chk("r_pc",    dec_pc_o,    32'h700);
        chk("r_instr", dec_instr_o, 32'h44444444);
        dec_ready_i = 1'b1;
        cycle();
        dec_ready_i = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
